async_fifo_read_stream_adapter: RTL and testbench

//   Read-side consumer of the asynchronous FIFO, in the RD_CLK domain. Drives the

---
 rtl/async_fifo_read_stream_adapter.sv | 102 ++++++++++
 tb/tb_async_fifo_read_stream_adapter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_stream_adapter.sv
// Read-side adapter for an asynchronous FIFO, in the RD_CLK domain.
// The FIFO returns data one cycle after RD_EN. A three-entry skid buffer
// absorbs those words so the block can sustain one word per cycle downstream.
// Reads are issued only against free buffer credit, which is computed from
// registered state and FIFO_EMPTY only. As a result, M_READY never reaches
// FIFO_RD_EN combinationally.
module async_fifo_read_stream_adapter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  RD_CLK,
  input  logic                  RD_RSTN,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_DATA,
  output logic                  FIFO_RD_EN,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [1:0]            LEVEL
);

  // Buffer slots 0..2; indices wrap from 2 back to 0.
  logic [DATA_WIDTH-1:0] buf_q [0:2];
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic [1:0]            rd_idx_q, rd_idx_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;

  logic                  credit_s;
  logic                  rd_en_s;
  logic                  push_s;
  logic                  pop_s;

  // Advance a buffer index, wrapping after the last slot.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    if (idx == 2'd2) begin
      return 2'd0;
    end else begin
      return idx + 2'd1;
    end
  endfunction

  // Next-state logic: read credit, push/pop bookkeeping and index updates.
  always_comb begin
    // A word already requested from the FIFO counts against the free slots.
    credit_s   = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
    // Reset forces the read enable low even while the clock is stopped.
    rd_en_s    = RD_RSTN && !FIFO_EMPTY && credit_s;
    push_s     = inflight_q;
    pop_s      = (count_q != 2'd0) && M_READY;

    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    count_d    = count_q;
    inflight_d = rd_en_s;

    if (push_s) begin
      wr_idx_d = next_idx(wr_idx_q);
    end else begin
      wr_idx_d = wr_idx_q;
    end

    if (pop_s) begin
      rd_idx_d = next_idx(rd_idx_q);
    end else begin
      rd_idx_d = rd_idx_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards buffered and in-flight words.
  always_ff @(posedge RD_CLK or negedge RD_RSTN) begin
    if (!RD_RSTN) begin
      wr_idx_q   <= 2'd0;
      rd_idx_q   <= 2'd0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Data slots capture the word that arrives one cycle after a read.
  always_ff @(posedge RD_CLK) begin
    if (push_s) begin
      buf_q[wr_idx_q] <= FIFO_DATA;
    end
  end

  assign FIFO_RD_EN = rd_en_s;
  assign M_VALID    = (count_q != 2'd0);
  assign M_DATA     = buf_q[rd_idx_q];
  assign LEVEL      = count_q;

endmodule

// File: tb/tb_async_fifo_read_stream_adapter.sv
// Self-checking bench for async_fifo_read_stream_adapter.
// The bench models the FIFO as a queue of words. A scoreboard queue holds the
// words already read from the FIFO but not yet accepted downstream. The
// expected buffer occupancy is kept as a plain integer.
module tb_async_fifo_read_stream_adapter;

  logic       clk;
  logic       rstn;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] level;

  async_fifo_read_stream_adapter #(.DATA_WIDTH(8)) dut (
    .RD_CLK    (clk),
    .RD_RSTN   (rstn),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA (fifo_data),
    .FIFO_RD_EN(rd_en),
    .M_DATA    (m_data),
    .M_VALID   (m_valid),
    .M_READY   (m_ready),
    .LEVEL     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] fq[$];     // words still inside the FIFO
  logic [7:0] sb[$];     // words read out of the FIFO, not yet delivered
  int         hs_cyc[$]; // cycle numbers of downstream handshakes
  int         m_level    = 0;
  int         m_inflight = 0;
  bit         rd_pending = 0;
  int         reads      = 0;
  int         delivered  = 0;
  int         cyc        = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, then account for the posedge.
  task automatic step(input bit rdy, input bit gate);
    bit exp_rd;
    bit hs;
    bit rd_now;
    @(negedge clk);
    if (rd_pending) begin
      if (fq.size() > 0) fifo_data = fq.pop_front();
      sb.push_back(fifo_data);
      rd_pending = 0;
    end
    fifo_empty = gate || (fq.size() == 0);
    m_ready    = rdy;
    #1;
    exp_rd = !fifo_empty && ((m_level + m_inflight) < 3);
    chk("rd_en", {31'd0, rd_en}, {31'd0, exp_rd});
    chk("level", {30'd0, level}, m_level);
    chk("valid", {31'd0, m_valid}, {31'd0, (m_level != 0)});
    if (m_level != 0 && sb.size() > 0) chk("data", {24'd0, m_data}, {24'd0, sb[0]});
    hs     = (m_level != 0) && rdy;
    rd_now = rd_en;
    if (rd_now) reads++;
    @(posedge clk);
    cyc++;
    if (hs) begin
      if (sb.size() > 0) void'(sb.pop_front());
      delivered++;
      hs_cyc.push_back(cyc);
    end
    m_level    = m_level + m_inflight - int'(hs);
    m_inflight = int'(exp_rd);
    rd_pending = rd_now;
  endtask

  // Assert reset away from any clock edge and check outputs before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    fifo_empty = 1'b1;
    rstn       = 1'b1;
    m_level    = 0;
    m_inflight = 0;
    rd_pending = 0;
    sb.delete();
    fq.delete();
  endtask

  task automatic load4();
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    fq.push_back(8'h33);
    fq.push_back(8'h44);
  endtask

  // Run with ready high until every loaded word is delivered, bounded.
  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (fq.size() != 0 || sb.size() != 0 || rd_pending); i++)
      step(1'b1, 1'b0);
    chk("drained", fq.size() + sb.size(), 32'd0);
  endtask

  initial begin
    int start_del;
    rstn       = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    m_ready    = 1'b0;
    #1;
    chk("init_valid", {31'd0, m_valid}, 32'd0);
    chk("init_level", {30'd0, level}, 32'd0);
    chk("init_rd_en", {31'd0, rd_en}, 32'd0);
    #20;
    rstn = 1'b1;

    // Test 1: reset asserted mid-cycle while words are buffered.
    load4();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    do_reset();

    // Test 2: streaming with ready high; 2-cycle latency, back-to-back output.
    load4();
    hs_cyc.delete();
    start_del = delivered;
    drain(20);
    chk("t2_count", delivered - start_del, 32'd4);
    if (hs_cyc.size() == 4) chk("t2_b2b", hs_cyc[3] - hs_cyc[0], 32'd3);
    else chk("t2_hs", hs_cyc.size(), 32'd4);

    // Test 3: backpressure fills the buffer with exactly three reads.
    load4();
    reads = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("t3_level", {30'd0, level}, 32'd3);
    chk("t3_reads", reads, 32'd3);
    chk("t3_head", {24'd0, m_data}, 32'h11);
    hs_cyc.delete();
    drain(20);
    if (hs_cyc.size() == 4) chk("t3_b2b", hs_cyc[3] - hs_cyc[0], 32'd3);
    else chk("t3_hs", hs_cyc.size(), 32'd4);

    // Test 4: FIFO_EMPTY toggling every other cycle.
    load4();
    start_del = delivered;
    for (int i = 0; i < 40 && (fq.size() != 0 || sb.size() != 0 || rd_pending); i++)
      step(1'b1, (i % 2) == 0);
    chk("t4_count", delivered - start_del, 32'd4);

    // Test 5: reset with two buffered words and one read in flight.
    load4();
    for (int i = 0; i < 20 && !(m_level == 2 && m_inflight == 1); i++) step(1'b0, 1'b0);
    chk("t5_pre", {31'd0, (m_level == 2 && m_inflight == 1)}, 32'd1);
    do_reset();
    step(1'b1, 1'b0);
    chk("t5_post_level", {30'd0, level}, 32'd0);
    fq.push_back(8'hA1);
    fq.push_back(8'hA2);
    fq.push_back(8'hA3);
    start_del = delivered;
    drain(20);
    chk("t5_count", delivered - start_del, 32'd3);

    // Test 6: 20 random words under random ready and empty gating.
    for (int i = 0; i < 20; i++) fq.push_back(8'($urandom_range(0, 255)));
    start_del = delivered;
    for (int i = 0; i < 600 && (fq.size() != 0 || sb.size() != 0 || rd_pending); i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    chk("t6_count", delivered - start_del, 32'd20);
    chk("t6_wraps", {31'd0, ((delivered - start_del) / 3) >= 6}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
